// File: rtl/pixel_row_sequencer.sv
// pixel_row_sequencer
//
// Frame controller for one pixel row column. A frame erases the pixels, exposes
// them, then reads each pixel out through the row mux and the shared SAR ADC.
// Each readout produces one registered sample, which is flagged if the ADC
// timed out.
//
// Ports
//   clk             single clock, rising edge
//   reset           synchronous, active-low
//   start           begin a frame (sampled only in IDLE)
//   abort           synchronous frame abort, beats start and adc_done
//   ERASE, EXPOSE   shared pixel control lines
//   decoder_select  row mux select, index of the pixel under readout
//   adc_reset       one-cycle clear pulse to the SAR ADC
//   adc_enable      SAR ADC enable, high while converting
//   adc_done        SAR ADC conversion done (only looked at while converting)
//   adc_data        SAR ADC code
//   pixel_valid     one-cycle sample strobe
//   pixel_data      captured code (0 on timeout)
//   pixel_index     index of the captured pixel
//   pixel_timeout   sample came from a timed-out conversion
//   busy            high whenever a frame is in progress
//   frame_done      one-cycle pulse at the end of a frame
//
// State table
//   state     | meaning
//   IDLE      | waiting for start, all outputs low
//   ERASE_ST  | ERASE high for ERASE_CYCLES
//   EXPOSE_ST | EXPOSE high for EXPOSE_CYCLES
//   SELECT    | mux points at idx, settling for SETTLE_CYCLES
//   CLEAR     | one-cycle ADC clear, drops any stale done
//   CONVERT   | ADC enabled, waiting up to TIMEOUT cycles for done
//   EMIT      | pixel_valid strobe for the captured sample
//   DONE      | frame_done strobe

module pixel_row_sequencer #(
  parameter int width         = 2,
  parameter int rows          = 2,
  parameter int resolution    = 8,
  parameter int ERASE_CYCLES  = 4,
  parameter int EXPOSE_CYCLES = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT       = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  ERASE,
  output logic                  EXPOSE,
  output logic [width:0]        decoder_select,
  output logic                  adc_reset,
  output logic                  adc_enable,
  input  logic                  adc_done,
  input  logic [resolution-1:0] adc_data,
  output logic                  pixel_valid,
  output logic [resolution-1:0] pixel_data,
  output logic [width:0]        pixel_index,
  output logic                  pixel_timeout,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int MAX_EE     = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int MAX_ST     = (SETTLE_CYCLES > TIMEOUT) ? SETTLE_CYCLES : TIMEOUT;
  localparam int MAX_CYCLES = (MAX_EE > MAX_ST) ? MAX_EE : MAX_ST;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam int IW         = width + 1;

  // Phase counter loads N-1 on entry and the state exits when it reads zero,
  // so a phase lasts exactly N cycles.
  localparam logic [CW-1:0] ERASE_LOAD   = CW'(ERASE_CYCLES - 1);
  localparam logic [CW-1:0] EXPOSE_LOAD  = CW'(EXPOSE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_IDX     = IW'(rows - 1);

  typedef enum logic [2:0] {
    IDLE,
    ERASE_ST,
    EXPOSE_ST,
    SELECT,
    CLEAR,
    CONVERT,
    EMIT,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          capture;
  logic          capture_timeout;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      pixel_data    <= '0;
      pixel_index   <= '0;
      pixel_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      if (capture) begin
        pixel_data    <= capture_timeout ? '0 : adc_data;
        pixel_index   <= idx;
        pixel_timeout <= capture_timeout;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = (cnt != '0) ? cnt - CW'(1) : '0;
    idx_nxt         = idx;
    capture         = 1'b0;
    capture_timeout = 1'b0;

    case (state)
      IDLE: begin
        idx_nxt = '0;
        if (start) begin
          state_nxt = ERASE_ST;
          cnt_nxt   = ERASE_LOAD;
        end
      end
      ERASE_ST: begin
        if (cnt == '0) begin
          state_nxt = EXPOSE_ST;
          cnt_nxt   = EXPOSE_LOAD;
        end
      end
      EXPOSE_ST: begin
        if (cnt == '0) begin
          state_nxt = SELECT;
          cnt_nxt   = SETTLE_LOAD;
          idx_nxt   = '0;
        end
      end
      SELECT: begin
        if (cnt == '0) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        state_nxt = CONVERT;
        cnt_nxt   = TIMEOUT_LOAD;
      end
      CONVERT: begin
        // A done that is already high on the first CONVERT cycle counts.
        if (adc_done) begin
          state_nxt = EMIT;
          cnt_nxt   = '0;
          capture   = 1'b1;
        end else if (cnt == '0) begin
          state_nxt       = EMIT;
          cnt_nxt         = '0;
          capture         = 1'b1;
          capture_timeout = 1'b1;
        end
      end
      EMIT: begin
        if (idx < LAST_IDX) begin
          state_nxt = SELECT;
          cnt_nxt   = SETTLE_LOAD;
          idx_nxt   = idx + IW'(1);
        end else begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase

    // Abort beats every other transition, including a capture on adc_done.
    if (abort) begin
      state_nxt       = IDLE;
      cnt_nxt         = '0;
      idx_nxt         = '0;
      capture         = 1'b0;
      capture_timeout = 1'b0;
    end
  end

  // Moore outputs: every strobe and enable is a pure state decode, so they all
  // drop on the edge that returns the FSM to IDLE (abort or reset).
  always_comb begin
    ERASE          = (state == ERASE_ST);
    EXPOSE         = (state == EXPOSE_ST);
    adc_reset      = (state == CLEAR);
    adc_enable     = (state == CONVERT);
    pixel_valid    = (state == EMIT);
    frame_done     = (state == DONE);
    busy           = (state != IDLE);
    decoder_select = '0;
    if ((state == SELECT) || (state == CLEAR) || (state == CONVERT) || (state == EMIT)) begin
      decoder_select = idx;
    end
  end

endmodule

// File: tb/tb_pixel_row_sequencer.sv
// Directed bench for pixel_row_sequencer: default instance plus a wider
// instance (width=3, rows=8, SETTLE_CYCLES=1). Outputs are sampled 1 ns after
// each rising edge.

module tb_pixel_row_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, abort;
  logic       erase, expose;
  logic [2:0] decoder_select;
  logic       adc_reset, adc_enable;
  logic       adc_done = 1'b0;
  logic [7:0] adc_data;
  logic       pixel_valid;
  logic [7:0] pixel_data;
  logic [2:0] pixel_index;
  logic       pixel_timeout, busy, frame_done;

  logic       start2;
  logic       abort2;
  logic       erase2, expose2;
  logic [3:0] decoder_select2;
  logic       adc_reset2, adc_enable2;
  logic       adc_done2 = 1'b0;
  logic [7:0] adc_data2;
  logic       pixel_valid2;
  logic [7:0] pixel_data2;
  logic [3:0] pixel_index2;
  logic       pixel_timeout2, busy2, frame_done2;

  int checks   = 0;
  int failures = 0;

  // ADC model for the default instance: done rises during the lat-th enabled
  // cycle; hang1 suppresses done for pixel 1; stale forces done high.
  int lat    = 9;
  bit hang1  = 1'b0;
  bit stale  = 1'b0;
  int conv_n = 0;

  always @(negedge clk) begin
    if (adc_enable) conv_n = conv_n + 1;
    else            conv_n = 0;
    adc_done = stale || (adc_enable && (conv_n >= lat) && !(hang1 && decoder_select == 3'd1));
  end
  assign adc_data = (decoder_select == 3'd0) ? 8'h5A : 8'hC3;

  // Wide instance ADC: done during the first enabled cycle, code = 0x30 + select.
  always @(negedge clk) adc_done2 = adc_enable2;
  assign adc_data2 = 8'h30 + {4'h0, decoder_select2};
  assign abort2 = 1'b0;

  pixel_row_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .ERASE(erase), .EXPOSE(expose), .decoder_select(decoder_select),
    .adc_reset(adc_reset), .adc_enable(adc_enable), .adc_done(adc_done), .adc_data(adc_data),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data), .pixel_index(pixel_index),
    .pixel_timeout(pixel_timeout), .busy(busy), .frame_done(frame_done)
  );

  pixel_row_sequencer #(.width(3), .rows(8), .SETTLE_CYCLES(1)) dut_wide (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2),
    .ERASE(erase2), .EXPOSE(expose2), .decoder_select(decoder_select2),
    .adc_reset(adc_reset2), .adc_enable(adc_enable2), .adc_done(adc_done2), .adc_data(adc_data2),
    .pixel_valid(pixel_valid2), .pixel_data(pixel_data2), .pixel_index(pixel_index2),
    .pixel_timeout(pixel_timeout2), .busy(busy2), .frame_done(frame_done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!pixel_valid && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {busy, erase, expose, decoder_select, adc_reset, adc_enable, pixel_valid, frame_done}, 32'h0);
  endtask

  initial begin
    int n, m, pulses, k;
    reset  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    start2 = 1'b0;
    tick();
    tick();
    chk("reset_outputs", {busy, erase, expose, decoder_select, adc_reset, adc_enable,
                          pixel_valid, frame_done, pixel_timeout, pixel_index, pixel_data}, 32'h0);
    reset = 1'b1;
    tick();
    chk_quiet("idle_after_reset");

    // Nominal frame, L=9
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("erase_on", {erase, expose, busy}, 32'b101);
    n = 0;
    while (erase && n < 50) begin n++; tick(); end
    chk("erase_len", n, 4);
    chk("expose_follows", {erase, expose}, 32'b01);
    n = 0;
    while (expose && n < 50) begin n++; tick(); end
    chk("expose_len", n, 16);
    chk("select_entry", {erase, expose, decoder_select, busy}, 32'b000001);
    wait_valid(100, n);
    chk("p0_latency", n, 12);
    chk("p0_sample", {pixel_timeout, pixel_index, pixel_data}, {20'h0, 1'b0, 3'd0, 8'h5A});
    chk("p0_select", decoder_select, 0);
    tick();
    wait_valid(100, m);
    chk("p1_spacing", 1 + m, 13);
    chk("p1_sample", {pixel_timeout, pixel_index, pixel_data}, {20'h0, 1'b0, 3'd1, 8'hC3});
    chk("p1_select", decoder_select, 1);
    tick();
    chk("frame_done", {frame_done, busy, pixel_valid}, 32'b110);
    tick();
    chk("busy_falls", {busy, frame_done}, 32'b00);

    // Timeout on pixel 1
    hang1 = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(200, n);
    chk("to_p0_latency", n, 32);
    chk("to_p0_sample", {pixel_timeout, pixel_index, pixel_data}, {20'h0, 1'b0, 3'd0, 8'h5A});
    tick();
    wait_valid(200, m);
    chk("to_p1_spacing", 1 + m, 68);
    chk("to_p1_sample", {pixel_timeout, pixel_index, pixel_data}, {20'h0, 1'b1, 3'd1, 8'h00});
    tick();
    chk("to_frame_done", frame_done, 1);
    tick();
    hang1 = 1'b0;

    // Stale done held across SELECT and CLEAR of pixel 1
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(200, n);
    chk("st_p0_sample", pixel_data, 8'h5A);
    stale = 1'b1;
    tick();
    chk("st_select1", {pixel_valid, adc_reset, adc_enable, decoder_select}, 32'b000001);
    tick();
    chk("st_select2", {pixel_valid, adc_reset, adc_enable, decoder_select}, 32'b000001);
    tick();
    chk("st_clear", {adc_reset, adc_enable, pixel_valid}, 32'b100);
    tick();
    chk("st_convert", {adc_reset, adc_enable, pixel_valid}, 32'b010);
    tick();
    chk("st_p1_sample", {pixel_valid, pixel_timeout, pixel_index, pixel_data}, {19'h0, 1'b1, 1'b0, 3'd1, 8'hC3});
    stale = 1'b0;
    tick();
    chk("st_frame_done", frame_done, 1);
    tick();

    // Abort mid-EXPOSE
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("ab_in_expose", expose, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_quiet("ab_expose_quiet");
    n = 0;
    repeat (40) begin tick(); if (pixel_valid || frame_done || busy) n++; end
    chk("ab_expose_silent", n, 0);

    // Abort mid-CONVERT, with start in the same cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!adc_enable && n < 100) begin n++; tick(); end
    chk("ab_reach_convert", n, 23);
    repeat (3) tick();
    chk("ab_in_convert", adc_enable, 1);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk_quiet("ab_convert_quiet");
    n = 0;
    repeat (100) begin tick(); if (pixel_valid || frame_done || busy) n++; end
    chk("ab_convert_silent", n, 0);

    // Clean frame, start held while busy, back-to-back start
    start = 1'b1;
    tick();
    tick();
    tick();
    start = 1'b0;
    n = 2;
    pulses = 0;
    while (!frame_done && n < 200) begin
      tick();
      n++;
      if (pixel_valid) pulses++;
    end
    chk("clean_frame_len", n, 46);
    chk("clean_pulses", pulses, 2);
    chk("clean_last_data", pixel_data, 8'hC3);
    start = 1'b1;
    tick();
    chk("done_start_ignored", {busy, erase}, 32'b00);
    tick();
    chk("idle_start_taken", {busy, erase}, 32'b11);
    start = 1'b0;

    // Reset during pixel 1 SELECT
    wait_valid(200, n);
    chk("rs_p0_latency", n, 32);
    tick();
    chk("rs_in_select", decoder_select, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rs_all_zero", {busy, erase, expose, decoder_select, adc_reset, adc_enable,
                        pixel_valid, frame_done, pixel_timeout, pixel_index, pixel_data}, 32'h0);
    tick();
    chk_quiet("rs_stays_idle");

    // Wide instance sweep
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    k = 0;
    n = 0;
    while (!frame_done2 && n < 400) begin
      tick();
      n++;
      if (pixel_valid2) begin
        chk("sw_index", pixel_index2, k);
        chk("sw_select", decoder_select2, pixel_index2);
        chk("sw_data", {pixel_timeout2, pixel_data2}, 32'h30 + k);
        k++;
      end
    end
    chk("sw_count", k, 8);
    chk("sw_frame_len", n, 52);
    chk("sw_frame_done", frame_done2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
